// File: rtl/spmx_mem_pkg.sv
// spmx_mem_pkg: shared types and defaults for the SDRAM byte-port arbiter.
package spmx_mem_pkg;

    localparam int unsigned ADDR_W = 25;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} arb_state_t;
    typedef enum logic [1:0] {P_LD, P_CPU, P_VID} port_t;

endpackage

// File: rtl/spmx_arb_prio.sv
// spmx_arb_prio: combinational winner select for the idle-state grant.
// Loader always wins; a starved video request beats the CPU; otherwise CPU beats video.
module spmx_arb_prio
    import spmx_mem_pkg::*;
(
    input  logic  ld_req_i,
    input  logic  cpu_req_i,
    input  logic  vid_req_i,
    input  logic  vid_starved_i,
    output port_t win_o,
    output logic  valid_o
);

    // Fixed-priority pick with the starvation override slotted below the loader.
    always_comb begin
        win_o   = P_LD;
        valid_o = 1'b1;
        if (ld_req_i) begin
            win_o = P_LD;
        end else if (vid_req_i && vid_starved_i) begin
            win_o = P_VID;
        end else if (cpu_req_i) begin
            win_o = P_CPU;
        end else if (vid_req_i) begin
            win_o = P_VID;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/spmx_mem_arbiter.sv
// spmx_mem_arbiter: shares the single sram byte port between loader, CPU and video.
// One access at a time: grant in IDLE, strobe in ISSUE, wait for mem_ready, ack in DONE.
// Optional: define SPMX_ARB_STARVE_GUARD_EN to promote video after VID_MAX_WAIT waiting cycles.
module spmx_mem_arbiter
    import spmx_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = spmx_mem_pkg::ADDR_W,
    parameter logic [5:0]  VID_MAX_WAIT = 6'd40
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_din,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_dout,
    output logic              vid_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ready
);

    arb_state_t        state_q, state_d;
    port_t             port_q, port_d, win;
    logic              win_valid, vid_starved;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d, vid_dout_q, vid_dout_d;
    logic              we_q, we_d;
    logic              ld_ack_q, ld_ack_d, cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;

    spmx_arb_prio u_prio (
        .ld_req_i      (ld_req),
        .cpu_req_i     (cpu_req),
        .vid_req_i     (vid_req),
        .vid_starved_i (vid_starved),
        .win_o         (win),
        .valid_o       (win_valid)
    );

`ifdef SPMX_ARB_STARVE_GUARD_EN
    logic [5:0] starve_q, starve_d;
    logic       vid_granted;

    // Count cycles video waits while someone else owns the port; saturate at the limit.
    always_comb begin
        vid_granted = (state_q == ST_IDLE) ? (win_valid && (win == P_VID))
                                           : (port_q == P_VID);
        starve_d = starve_q;
        if (vid_ack_q) begin
            starve_d = '0;
        end else if (vid_req && !vid_granted && (starve_q != VID_MAX_WAIT)) begin
            starve_d = starve_q + 6'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign vid_starved = (starve_q == VID_MAX_WAIT);
`else
    logic unused_vid_max_wait;
    assign unused_vid_max_wait = ^VID_MAX_WAIT;
    assign vid_starved         = 1'b0;
`endif

    // Next-state and datapath: latch the winner in IDLE, capture read data and ack in WAIT.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = we_q;
        cpu_dout_d = cpu_dout_q;
        vid_dout_d = vid_dout_q;
        ld_ack_d   = 1'b0;
        cpu_ack_d  = 1'b0;
        vid_ack_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    port_d  = win;
                    state_d = ST_ISSUE;
                    case (win)
                        P_LD: begin
                            addr_d = ld_addr;
                            din_d  = ld_din;
                            we_d   = 1'b1;
                        end
                        P_CPU: begin
                            addr_d = cpu_addr;
                            din_d  = cpu_din;
                            we_d   = cpu_we;
                        end
                        default: begin
                            addr_d = vid_addr;
                            din_d  = '0;
                            we_d   = 1'b0;
                        end
                    endcase
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                    case (port_q)
                        P_LD: ld_ack_d = 1'b1;
                        P_CPU: begin
                            cpu_ack_d = 1'b1;
                            if (!we_q) begin
                                cpu_dout_d = mem_dout;
                            end
                        end
                        default: begin
                            vid_ack_d  = 1'b1;
                            vid_dout_d = mem_dout;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            port_q     <= P_LD;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            cpu_dout_q <= '0;
            vid_dout_q <= '0;
            ld_ack_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            cpu_dout_q <= cpu_dout_d;
            vid_dout_q <= vid_dout_d;
            ld_ack_q   <= ld_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_ack_q  <= vid_ack_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    assign mem_we   = (state_q == ST_ISSUE) &&  we_q;
    assign mem_rd   = (state_q == ST_ISSUE) && !we_q;
    assign ld_ack   = ld_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign vid_ack  = vid_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign vid_dout = vid_dout_q;

endmodule

// File: tb/tb_spmx_mem_arbiter.sv
// tb_spmx_mem_arbiter: directed scoreboard bench for spmx_mem_arbiter with a byte sram model.
module tb_spmx_mem_arbiter;
    import spmx_mem_pkg::*;

    localparam int unsigned AW = 25;
    localparam int VMW = 40;
    localparam logic [AW-1:0] CPU_ADDR = 25'h0C000;
    localparam logic [AW-1:0] VID_ADDR = 25'h01234;

    logic          clk_sys, reset;
    logic          ld_req, ld_ack, cpu_req, cpu_we, cpu_ack, vid_req, vid_ack;
    logic [AW-1:0] ld_addr, cpu_addr, vid_addr, mem_addr;
    logic [7:0]    ld_din, cpu_din, cpu_dout, vid_dout, mem_din, mem_dout;
    logic          mem_we, mem_rd, mem_ready;

    spmx_mem_arbiter #(.ADDR_W(AW), .VID_MAX_WAIT(6'd40)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // sram model state
    logic [7:0] mem [int];
    int         wcnt [int];
    int         lat, inj_req, inj_done, strobe_cnt, pend_cnt;
    logic       pend;
    logic [7:0] pend_data;

    function automatic logic [7:0] bg(input int a);
        logic [31:0] av;
        av = a;
        return (a == int'(CPU_ADDR)) ? 8'hA5 : (av[7:0] ^ 8'h96);
    endfunction

    // sram model: sees strobes at the falling edge, answers lat cycles later
    initial begin
        mem_ready = 1'b0; mem_dout = '0; pend = 1'b0; pend_cnt = 0;
        inj_done = 0; strobe_cnt = 0; pend_data = '0;
        forever begin
            @(negedge clk_sys);
            mem_ready = 1'b0;
            if (pend) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt <= 0) begin
                    mem_ready = 1'b1;
                    mem_dout  = pend_data;
                    pend      = 1'b0;
                end
            end
            if (inj_req != inj_done) begin
                inj_done  = inj_done + 1;
                mem_ready = 1'b1;
            end
            if (mem_we || mem_rd) begin
                strobe_cnt = strobe_cnt + 1;
                if (mem_we) begin
                    mem[int'(mem_addr)]  = mem_din;
                    wcnt[int'(mem_addr)] = wcnt.exists(int'(mem_addr)) ? wcnt[int'(mem_addr)] + 1 : 1;
                end else begin
                    pend_data = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : bg(int'(mem_addr));
                end
                if (lat > 0) begin
                    pend     = 1'b1;
                    pend_cnt = lat;
                end
            end
        end
    end

    // scoreboard and bookkeeping
    int          nvec, nerr, tick_no, total_acks;
    logic [8:0]  q_ld[$], q_cpu[$], q_vid[$];
    port_t       ack_log[$];
    logic [33:0] strobe_log[$];
    logic [2:0]  ack_seen;
    logic        rdy_at_edge, cpu_stream;
    int          ld_ack_cnt, vid_ack_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [8:0] e;
        logic r;
        @(posedge clk_sys);
        r = mem_ready;
        #1;
        tick_no++;
        rdy_at_edge = r;
        ack_seen = {vid_ack, cpu_ack, ld_ack};
        if (mem_we || mem_rd) strobe_log.push_back({mem_we, mem_addr, mem_din});
        if (ld_ack) begin
            total_acks++; ld_ack_cnt++; ack_log.push_back(P_LD);
            chk("ld_ack_expected", 32'(q_ld.size() > 0), 1);
            if (q_ld.size() > 0) e = q_ld.pop_front();
        end
        if (cpu_ack) begin
            total_acks++; ack_log.push_back(P_CPU);
            chk("cpu_ack_expected", 32'(q_cpu.size() > 0), 1);
            if (q_cpu.size() > 0) begin
                e = q_cpu.pop_front();
                if (e[8]) chk("cpu_dout", 32'(cpu_dout), 32'(e[7:0]));
            end
            if (cpu_stream) q_cpu.push_back({1'b1, 8'hA5});
        end
        if (vid_ack) begin
            total_acks++; vid_ack_cnt++; ack_log.push_back(P_VID);
            chk("vid_ack_expected", 32'(q_vid.size() > 0), 1);
            if (q_vid.size() > 0) begin
                e = q_vid.pop_front();
                chk("vid_dout", 32'(vid_dout), 32'(e[7:0]));
            end
        end
    endtask

    task automatic wait_ack(input int p, input int budget, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (ack_seen[p]) got = 1'b1;
        end
        chk({tag, "_ack"}, 32'(got), 1);
    endtask

    initial begin
        int t0, ack_tick, rdy_tick, v0, a0, s0, bad, first_vid;
        logic got;
        nvec = 0; nerr = 0; tick_no = 0; total_acks = 0; ld_ack_cnt = 0; vid_ack_cnt = 0;
        cpu_stream = 1'b0; lat = 1; inj_req = 0; ack_seen = '0; rdy_at_edge = 1'b0;
        reset = 1'b1; ld_req = 0; cpu_req = 0; vid_req = 0; cpu_we = 0;
        ld_addr = '0; cpu_addr = '0; vid_addr = '0; ld_din = '0; cpu_din = '0;
        repeat (3) tick();
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_din", 32'(mem_din), 0);
        chk("rst_strobes", 32'({mem_we, mem_rd}), 0);
        chk("rst_acks", 32'({ld_ack, cpu_ack, vid_ack}), 0);
        chk("rst_cpu_dout", 32'(cpu_dout), 0);
        chk("rst_vid_dout", 32'(vid_dout), 0);
        reset = 1'b0;
        tick();

        // CPU read, ready two cycles after the strobe
        lat = 2; strobe_log.delete();
        cpu_req = 1; cpu_we = 0; cpu_addr = CPU_ADDR;
        q_cpu.push_back({1'b1, 8'hA5});
        t0 = tick_no; ack_tick = -1; rdy_tick = -2;
        for (int i = 0; i < 20 && ack_tick < 0; i++) begin
            tick();
            if (rdy_at_edge) rdy_tick = tick_no;
            if (cpu_ack) begin ack_tick = tick_no; cpu_req = 0; end
        end
        chk("cpu_rd_strobes", 32'(strobe_log.size()), 1);
        chk("cpu_rd_strobe", 32'(strobe_log.size() > 0 ? strobe_log[0] : '0), 32'({1'b0, CPU_ADDR, 8'h00}));
        chk("cpu_rd_latency", 32'(ack_tick - t0), 4);
        chk("cpu_ack_after_ready", 32'(ack_tick), 32'(rdy_tick));
        repeat (3) tick();
        chk("cpu_dout_held", 32'(cpu_dout), 32'h A5);

        // loader and CPU request in the same cycle
        lat = 1; strobe_log.delete(); ack_log.delete();
        ld_req = 1; ld_addr = 25'h00100; ld_din = 8'h3C;
        cpu_req = 1; cpu_we = 0; cpu_addr = CPU_ADDR;
        q_ld.push_back({1'b0, 8'h3C}); q_cpu.push_back({1'b1, 8'hA5});
        for (int i = 0; i < 30 && ack_log.size() < 2; i++) begin
            tick();
            if (ld_ack) ld_req = 0;
            if (cpu_ack) cpu_req = 0;
        end
        repeat (3) tick();
        chk("cont_ack_count", 32'(ack_log.size()), 2);
        chk("cont_first_ack", 32'(ack_log.size() > 0 ? ack_log[0] : P_VID), 32'(P_LD));
        chk("cont_second_ack", 32'(ack_log.size() > 1 ? ack_log[1] : P_VID), 32'(P_CPU));
        chk("cont_ld_strobe", 32'(strobe_log.size() > 0 ? strobe_log[0] : '0), 32'({1'b1, 25'h00100, 8'h3C}));
        chk("cont_cpu_strobe", 32'(strobe_log.size() > 1 ? strobe_log[1][33:8] : '0), 32'({1'b0, CPU_ADDR}));

        // continuous CPU traffic with a pending video request
        cpu_stream = 1'b1; q_cpu.push_back({1'b1, 8'hA5});
        cpu_req = 1; cpu_we = 0; cpu_addr = CPU_ADDR;
        vid_req = 1; vid_addr = VID_ADDR; q_vid.push_back({1'b1, bg(int'(VID_ADDR))});
        v0 = vid_ack_cnt;
`ifdef SPMX_ARB_STARVE_GUARD_EN
        first_vid = -1; got = 1'b0;
        for (int i = 1; i <= VMW + 20 && !got; i++) begin
            tick();
            if (first_vid < 0 && mem_rd && mem_addr == VID_ADDR) first_vid = i;
            if (vid_ack) begin got = 1'b1; vid_req = 0; end
        end
        chk("vid_grant_in_bound", 32'(first_vid >= 1 && first_vid <= VMW + 4), 1);
        chk("vid_served", 32'(vid_ack_cnt - v0), 1);
        chk("vid_dout_starve", 32'(vid_dout), 32'(bg(int'(VID_ADDR))));
        cpu_stream = 1'b0;
        wait_ack(1, 20, "cpu_stream_end");
        cpu_req = 0;
`else
        first_vid = 0; got = 1'b0;
        repeat (VMW + 60) tick();
        chk("vid_not_granted", 32'(vid_ack_cnt - v0), 0);
        cpu_stream = 1'b0;
        wait_ack(1, 20, "cpu_stream_end");
        cpu_req = 0;
        wait_ack(2, 20, "vid_after_cpu");
        vid_req = 0;
        chk("vid_dout_after_cpu", 32'(vid_dout), 32'(bg(int'(VID_ADDR))));
`endif
        repeat (2) tick();

        // reset while waiting, then a stray ready after release
        lat = 0; a0 = total_acks;
        cpu_req = 1; cpu_we = 1; cpu_addr = 25'h00300; cpu_din = 8'h99;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (mem_we) got = 1'b1;
        end
        chk("rstmid_strobe", 32'(got), 1);
        tick();
        reset = 1'b1; cpu_req = 0;
        tick();
        reset = 1'b0;
        tick();
        inj_req = inj_req + 1;
        repeat (4) tick();
        chk("rstmid_no_ack", 32'(total_acks - a0), 0);
        chk("rstmid_mem_addr", 32'(mem_addr), 0);
        chk("rstmid_mem_din", 32'(mem_din), 0);
        chk("rstmid_strobes", 32'({mem_we, mem_rd}), 0);
        chk("rstmid_cpu_dout", 32'(cpu_dout), 0);
        chk("rstmid_vid_dout", 32'(vid_dout), 0);

        // sustained loader writes
        lat = 1; a0 = ld_ack_cnt; s0 = strobe_cnt;
        for (int a = 0; a < 256; a++) begin
            ld_addr = 25'(a); ld_din = 8'(a) ^ 8'h5A; ld_req = 1;
            q_ld.push_back({1'b0, ld_din});
            wait_ack(0, 20, "dl");
            ld_req = 0;
        end
        repeat (3) tick();
        chk("dl_ack_count", 32'(ld_ack_cnt - a0), 256);
        chk("dl_strobe_count", 32'(strobe_cnt - s0), 256);
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            if (!mem.exists(a) || mem[a] !== (8'(a) ^ 8'h5A)) bad++;
            if (!wcnt.exists(a) || wcnt[a] != 1) bad++;
        end
        chk("dl_mem_contents", 32'(bad), 0);
        chk("sb_drained", 32'(q_ld.size() + q_cpu.size() + q_vid.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
